// File: rtl/i2s_adc_receiver.sv
`timescale 1ns/1ps
// I2S slave receiver: oversamples BCLK/WS/DATA on MasterCLK and
// presents each stereo frame as a left/right pair with valid/ready.
module i2s_adc_receiver #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    MasterCLK,
  input  logic                    Reset,
  input  logic                    I2S_BCLK,
  input  logic                    I2S_WS,
  input  logic                    I2S_DATA,
  output logic [SAMPLE_WIDTH-1:0] LeftSample,
  output logic [SAMPLE_WIDTH-1:0] RightSample,
  output logic                    SampleValid,
  input  logic                    SampleReady,
  output logic                    Overrun,
  output logic                    Locked
);

  localparam int CW = $clog2(SAMPLE_WIDTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(SAMPLE_WIDTH);
  localparam logic [SAMPLE_WIDTH-1:0] MSB =
    SAMPLE_WIDTH'(1) << (SAMPLE_WIDTH - 1);

  localparam logic [1:0] SYNC  = 2'd0;
  localparam logic [1:0] LEFT  = 2'd1;
  localparam logic [1:0] RIGHT = 2'd2;

  logic [SYNC_STAGES-1:0] bclk_sync;
  logic [SYNC_STAGES-1:0] ws_sync;
  logic [SYNC_STAGES-1:0] sd_sync;
  logic                   bclk_prev;

  logic bclk_s;
  logic ws_s;
  logic sd_s;
  logic rise;

  logic [1:0]              state;
  logic                    ws_prev;
  logic [CW-1:0]           cnt;
  logic [SAMPLE_WIDTH-1:0] shift;
  logic [SAMPLE_WIDTH-1:0] left_word;
  logic [SAMPLE_WIDTH-1:0] right_word;
  logic                    frame_done;

  logic [SAMPLE_WIDTH-1:0] bit_mask;
  logic [SAMPLE_WIDTH-1:0] word_next;
  logic                    word_end;
  logic                    load;

  always_ff @(posedge MasterCLK) begin
    if (Reset) begin
      bclk_sync <= '0;
      ws_sync   <= '0;
      sd_sync   <= '0;
      bclk_prev <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], I2S_BCLK};
      ws_sync   <= {ws_sync[SYNC_STAGES-2:0], I2S_WS};
      sd_sync   <= {sd_sync[SYNC_STAGES-2:0], I2S_DATA};
      bclk_prev <= bclk_s;
    end
  end

  assign bclk_s = bclk_sync[SYNC_STAGES-1];
  assign ws_s   = ws_sync[SYNC_STAGES-1];
  assign sd_s   = sd_sync[SYNC_STAGES-1];
  assign rise   = bclk_s & ~bclk_prev;

  // Mask is zero once the counter saturates, so extra bits drop out.
  assign bit_mask  = MSB >> cnt;
  assign word_next = shift | (sd_s ? bit_mask : '0);
  assign word_end  = ws_s != ws_prev;

  always_ff @(posedge MasterCLK) begin
    if (Reset) begin
      state      <= SYNC;
      ws_prev    <= 1'b0;
      cnt        <= '0;
      shift      <= '0;
      left_word  <= '0;
      right_word <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (rise) begin
        ws_prev <= ws_s;
        if (word_end || state == SYNC) begin
          cnt   <= '0;
          shift <= '0;
        end else begin
          shift <= word_next;
          if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
        end
        case (state)
          SYNC: begin
            if (ws_prev && !ws_s) state <= LEFT;
          end
          LEFT: begin
            if (word_end) begin
              left_word <= word_next;
              state     <= RIGHT;
            end
          end
          RIGHT: begin
            if (word_end) begin
              right_word <= word_next;
              frame_done <= 1'b1;
              state      <= LEFT;
            end
          end
          default: state <= SYNC;
        endcase
      end
    end
  end

  assign load   = frame_done & (~SampleValid | SampleReady);
  assign Locked = state != SYNC;

  always_ff @(posedge MasterCLK) begin
    if (Reset) begin
      LeftSample  <= '0;
      RightSample <= '0;
      SampleValid <= 1'b0;
      Overrun     <= 1'b0;
    end else if (load) begin
      LeftSample  <= left_word;
      RightSample <= right_word;
      SampleValid <= 1'b1;
    end else begin
      if (frame_done) Overrun <= 1'b1;
      if (SampleValid && SampleReady) SampleValid <= 1'b0;
    end
  end

endmodule
